calc_seq: RTL and testbench

//  Parametrised successor of the serial-entry calculator. Accepts operand A, an operator code,
//  and, for binary ops only, operand B, one word at a time over a single valid/ready input port.

---
 rtl/calc_seq.sv | 199 +++++++++++++++++++
 tb/tb_calc_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq.sv
// Serial-entry calculator: operand A, operator, optional operand B over one valid/ready port.
// Iterative shift-add multiplier for MUL/SQR; result may be chained back into operand A.
module calc_seq #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validIn,
    output logic             readyIn,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             chainIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             validOut,
    output logic             ovfOut,
    output logic             errOut
);
    // state  | meaning
    // S_OPA  | waiting for operand A
    // S_OPR  | waiting for operator word
    // S_OPB  | waiting for operand B (binary ops)
    // S_EXEC | computing; MUL/SQR spend one setup cycle then WIDTH iterations
    // S_RES  | publish result, optionally chain it into A
    typedef enum logic [2:0] {S_OPA, S_OPR, S_OPB, S_EXEC, S_RES} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_SQR = OPW'(2);
    localparam logic [OPW-1:0] OP_MUL = OPW'(3);
    localparam logic [OPW-1:0] OP_INC = OPW'(4);
    localparam logic [OPW-1:0] OP_DEC = OPW'(5);
    localparam logic [OPW-1:0] OP_CLR = OPW'(6);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [OPW-1:0]       op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 run_q, run_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d, prod_q, prod_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 rovf_q, rovf_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic                 ovf_q, ovf_d, vout_q, vout_d, err_q, err_d;
    logic                 accept;
    logic [OPW-1:0]       op_in;

    assign readyIn  = (state_q == S_OPA) || (state_q == S_OPR) || (state_q == S_OPB);
    assign accept   = validIn && readyIn;
    assign op_in    = dataIn[OPW-1:0];
    assign dataOut  = dout_q;
    assign validOut = vout_q;
    assign ovfOut   = ovf_q;
    assign errOut   = err_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        res_d    = res_q;
        rovf_d   = rovf_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        vout_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_OPA: begin
                if (accept) begin
                    a_d     = dataIn;
                    state_d = S_OPR;
                end
            end
            S_OPR: begin
                if (accept) begin
                    op_d = op_in;
                    if (op_in == OP_ADD || op_in == OP_SUB || op_in == OP_MUL) begin
                        state_d = S_OPB;
                    end else if (op_in == OP_SQR || op_in == OP_INC || op_in == OP_DEC) begin
                        state_d = S_EXEC;
                    end else if (op_in == OP_CLR) begin
                        dout_d  = '0;
                        ovf_d   = 1'b0;
                        state_d = S_OPA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_OPA;
                    end
                end
            end
            S_OPB: begin
                if (accept) begin
                    b_d     = dataIn;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        {rovf_d, res_d} = {1'b0, a_q} + {1'b0, b_q};
                        state_d = S_RES;
                    end
                    OP_SUB: begin
                        res_d   = a_q - b_q;
                        rovf_d  = (a_q < b_q);
                        state_d = S_RES;
                    end
                    OP_INC: begin
                        res_d   = a_q + WIDTH'(1);
                        rovf_d  = &a_q;
                        state_d = S_RES;
                    end
                    OP_DEC: begin
                        res_d   = a_q - WIDTH'(1);
                        rovf_d  = (a_q == '0);
                        state_d = S_RES;
                    end
                    default: begin
                        if (!run_q) begin
                            run_d    = 1'b1;
                            cnt_d    = CW'(WIDTH - 1);
                            mcand_d  = {{WIDTH{1'b0}}, a_q};
                            mplier_d = (op_q == OP_SQR) ? a_q : b_q;
                            prod_d   = '0;
                        end else begin
                            if (mplier_q[0]) begin
                                prod_d = prod_q + mcand_q;
                            end
                            mcand_d  = mcand_q << 1;
                            mplier_d = mplier_q >> 1;
                            cnt_d    = cnt_q - CW'(1);
                            // terminal count: this was the last partial product
                            if (cnt_q == '0) begin
                                run_d   = 1'b0;
                                res_d   = prod_d[WIDTH-1:0];
                                rovf_d  = |prod_d[2*WIDTH-1:WIDTH];
                                state_d = S_RES;
                            end
                        end
                    end
                endcase
            end
            S_RES: begin
                dout_d = res_q;
                ovf_d  = rovf_q;
                vout_d = 1'b1;
                if (chainIn) begin
                    a_d     = res_q;
                    state_d = S_OPR;
                end else begin
                    state_d = S_OPA;
                end
            end
            default: state_d = S_OPA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OPA;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            res_q    <= '0;
            rovf_q   <= 1'b0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            vout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            res_q    <= res_d;
            rovf_q   <= rovf_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            vout_q   <= vout_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_calc_seq.sv
// Randomized self-checking bench for calc_seq (WIDTH=16 and WIDTH=8 instances)
// against an arithmetic reference model.
module tb_calc_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] din = '0;
    logic        chain = 1'b0;
    bit          sel = 1'b0;

    logic        rdy16, vout16, ovf16, err16;
    logic [15:0] dout16;
    logic        rdy8, vout8, ovf8, err8;
    logic [7:0]  dout8;

    logic        g_rdy, g_vout, g_ovf, g_err;
    logic [15:0] g_dout;

    int n_vec = 0;
    int n_err = 0;

    longint m_a = 0, m_dout = 0;
    bit     m_ovf = 0;

    always #5 clk = ~clk;

    calc_seq #(.WIDTH(16), .OPW(3)) u_dut16 (
        .clk(clk), .rst(rst), .validIn(valid && !sel), .readyIn(rdy16),
        .dataIn(din), .chainIn(chain), .dataOut(dout16), .validOut(vout16),
        .ovfOut(ovf16), .errOut(err16));

    calc_seq #(.WIDTH(8), .OPW(3)) u_dut8 (
        .clk(clk), .rst(rst), .validIn(valid && sel), .readyIn(rdy8),
        .dataIn(din[7:0]), .chainIn(chain), .dataOut(dout8), .validOut(vout8),
        .ovfOut(ovf8), .errOut(err8));

    assign g_rdy  = sel ? rdy8  : rdy16;
    assign g_vout = sel ? vout8 : vout16;
    assign g_ovf  = sel ? ovf8  : ovf16;
    assign g_err  = sel ? err8  : err16;
    assign g_dout = sel ? {8'h00, dout8} : dout16;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void ref_calc(input int w, input int op, input longint a, input longint b,
                                     output longint res, output bit ovf);
        longint m;
        longint f;
        m = longint'(1) << w;
        case (op)
            0:       f = a + b;
            1:       f = a - b;
            2:       f = a * a;
            3:       f = a * b;
            4:       f = a + 1;
            default: f = a - 1;
        endcase
        ovf = (f < 0) || (f >= m);
        res = ((f % m) + m) % m;
    endfunction

    task automatic put(input longint w);
        int t;
        t = 0;
        @(negedge clk);
        while (!g_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!g_rdy) chk("ready_timeout", longint'(g_rdy), 1);
        valid = 1'b1;
        din   = 16'(w);
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic run_op(input int op, input longint a, input longint b, input bit send_a,
                          input bit ch, input string tag);
        int     w, lat, exp_lat;
        bit     got, busy_ok;
        longint e_res;
        bit     e_ovf;
        w = sel ? 8 : 16;
        chain = ch;
        if (send_a) m_a = a;
        ref_calc(w, op, m_a, b, e_res, e_ovf);
        exp_lat = (op == 2 || op == 3) ? w + 2 : 2;
        if (send_a) put(a);
        put(op);
        if (op == 0 || op == 1 || op == 3) put(b);
        lat = 0; got = 0; busy_ok = 1;
        while (lat < 100 && !got) begin
            @(posedge clk);
            #1;
            lat++;
            if (g_vout) got = 1;
            else if (g_rdy) busy_ok = 0;
        end
        chk({tag, "_valid"}, longint'(got), 1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, longint'(g_dout), e_res);
        chk({tag, "_ovf"}, longint'(g_ovf), longint'(e_ovf));
        chk({tag, "_busy"}, longint'(busy_ok), 1);
        @(posedge clk);
        #1 chk({tag, "_strobe"}, longint'(g_vout), 0);
        m_dout = e_res;
        m_ovf  = e_ovf;
        if (ch) m_a = e_res;
        chain = 1'b0;
    endtask

    task automatic rand_ops(input int n);
        bit     prev_ch;
        longint mask, a, b;
        int     op;
        bit     ch;
        mask = (longint'(1) << (sel ? 8 : 16)) - 1;
        prev_ch = 0;
        for (int i = 0; i < n; i++) begin
            op = int'($urandom_range(0, 5));
            a  = longint'($urandom) & mask;
            b  = longint'($urandom) & mask;
            if ($urandom_range(0, 5) == 0) a = mask;
            if ($urandom_range(0, 5) == 0) a = 0;
            if ($urandom_range(0, 5) == 0) b = mask;
            ch = ($urandom_range(0, 2) == 0);
            run_op(op, a, b, !prev_ch, ch, "rand");
            prev_ch = ch;
        end
        if (prev_ch) begin
            run_op(0, 0, 0, 0, 0, "rand_tail");
        end
    endtask

    initial begin
        bit seen;
        int t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_dout", longint'(dout16), 0);
        chk("rst_vout", longint'(vout16), 0);
        chk("rst_ovf", longint'(ovf16), 0);
        chk("rst_err", longint'(err16), 0);
        chk("rst_ready", longint'(rdy16), 1);
        chk("rst_ready8", longint'(rdy8), 1);

        run_op(2, 2, 0, 1, 0, "sqr2");
        run_op(3, 300, 300, 1, 0, "mul300");
        run_op(4, 65535, 0, 1, 0, "inc_wrap");
        run_op(1, 5, 7, 1, 0, "sub_borrow");
        run_op(5, 0, 0, 1, 0, "dec_wrap");
        run_op(0, 3, 4, 1, 1, "add_chain");
        run_op(3, 0, 6, 0, 0, "mul_chained");

        put(1234);
        put(7);
        chk("err_pulse", longint'(err16), 1);
        chk("err_hold", longint'(dout16), m_dout);
        @(posedge clk);
        #1 chk("err_once", longint'(err16), 0);

        put(10);
        put(0);
        put(20);
        valid = 1'b1;
        din   = 16'd99;
        t = 0;
        while (!vout16 && t < 50) begin
            @(posedge clk);
            #1 t++;
        end
        valid = 1'b0;
        chk("busy_drop_data", longint'(dout16), 30);
        m_dout = 30; m_ovf = 0;
        run_op(0, 1, 1, 1, 0, "after_drop");

        put(300);
        put(3);
        put(300);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_ready", longint'(rdy16), 1);
        chk("midrst_dout", longint'(dout16), 0);
        chk("midrst_ovf", longint'(ovf16), 0);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1 if (vout16) seen = 1;
        end
        chk("midrst_novalid", longint'(seen), 0);
        m_a = 0; m_dout = 0; m_ovf = 0;

        rand_ops(40);

        sel = 1'b1;
        m_a = 0; m_dout = 0; m_ovf = 0;
        run_op(0, 200, 100, 1, 1, "w8_add");
        put(6);
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (vout8) seen = 1;
        end
        chk("w8_clr_data", longint'(dout8), 0);
        chk("w8_clr_ovf", longint'(ovf8), 0);
        chk("w8_clr_novalid", longint'(seen), 0);
        m_dout = 0; m_ovf = 0;
        rand_ops(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
